// File: rtl/dx_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall handling
// and saturating bubble/flush event counters.
module dx_hazard_reg #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fd_valid,
  input  logic [3:0]       fd_rs,
  input  logic [3:0]       fd_rt,
  input  logic [3:0]       fd_rd,
  input  logic             fd_uses_rs,
  input  logic             fd_uses_rt,
  input  logic [15:0]      fd_rs_data,
  input  logic [15:0]      fd_rt_data,
  input  logic [15:0]      fd_imm,
  input  logic             fd_regwrite,
  input  logic             fd_memread,
  input  logic             fd_memwrite,
  input  logic [3:0]       fd_alu_op,
  input  logic             flush,
  input  logic             ext_stall,
  output logic             dx_valid,
  output logic             dx_regwrite,
  output logic             dx_memread,
  output logic             dx_memwrite,
  output logic [3:0]       dx_rs,
  output logic [3:0]       dx_rt,
  output logic [3:0]       dx_rd,
  output logic [15:0]      dx_rs_data,
  output logic [15:0]      dx_rt_data,
  output logic [15:0]      dx_imm,
  output logic [3:0]       dx_alu_op,
  output logic             stall_fd,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [3:0]  rd;
    logic [3:0]  alu_op;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic [15:0] imm;
  } dx_t;

  dx_t        dx_q, fd_pkt;
  logic       rs_hit, rt_hit, lu;
  logic [CNT_W-1:0] bcnt_q, fcnt_q;

  // A store's rt is only needed in MEM, where it can be forwarded, so it never stalls.
  assign rs_hit = fd_uses_rs && (fd_rs == dx_q.rd);
  assign rt_hit = fd_uses_rt && (fd_rt == dx_q.rd) && !fd_memwrite;
  assign lu     = fd_valid && dx_q.valid && dx_q.memread && dx_q.regwrite &&
                  (dx_q.rd != 4'd0) && (rs_hit || rt_hit);

  assign stall_fd = !rst && (ext_stall || (!flush && lu));

  // Invalid slots still carry their fields but never assert control.
  always_comb begin
    fd_pkt          = '0;
    fd_pkt.valid    = fd_valid;
    fd_pkt.regwrite = fd_valid && fd_regwrite;
    fd_pkt.memread  = fd_valid && fd_memread;
    fd_pkt.memwrite = fd_valid && fd_memwrite;
    fd_pkt.rs       = fd_rs;
    fd_pkt.rt       = fd_rt;
    fd_pkt.rd       = fd_rd;
    fd_pkt.alu_op   = fd_alu_op;
    fd_pkt.rs_data  = fd_rs_data;
    fd_pkt.rt_data  = fd_rt_data;
    fd_pkt.imm      = fd_imm;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dx_q   <= '0;
      bcnt_q <= '0;
      fcnt_q <= '0;
    end else if (!ext_stall) begin
      if (flush) begin
        dx_q <= '0;
        if (fcnt_q != '1) fcnt_q <= fcnt_q + CNT_W'(1);
      end else if (lu) begin
        dx_q <= '0;
        if (bcnt_q != '1) bcnt_q <= bcnt_q + CNT_W'(1);
      end else begin
        dx_q <= fd_pkt;
      end
    end
  end

  assign dx_valid     = dx_q.valid;
  assign dx_regwrite  = dx_q.regwrite;
  assign dx_memread   = dx_q.memread;
  assign dx_memwrite  = dx_q.memwrite;
  assign dx_rs        = dx_q.rs;
  assign dx_rt        = dx_q.rt;
  assign dx_rd        = dx_q.rd;
  assign dx_alu_op    = dx_q.alu_op;
  assign dx_rs_data   = dx_q.rs_data;
  assign dx_rt_data   = dx_q.rt_data;
  assign dx_imm       = dx_q.imm;
  assign bubble_count = bcnt_q;
  assign flush_count  = fcnt_q;

endmodule

// File: tb/tb_dx_hazard_reg.sv
// Scoreboard bench for dx_hazard_reg; a 4-bit-counter instance shares the
// stimulus so counter saturation is reached in a short run.
module tb_dx_hazard_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fd_valid, fd_uses_rs, fd_uses_rt;
  logic        fd_regwrite, fd_memread, fd_memwrite, flush, ext_stall;
  logic [3:0]  fd_rs, fd_rt, fd_rd, fd_alu_op;
  logic [15:0] fd_rs_data, fd_rt_data, fd_imm;

  logic        dx_valid, dx_regwrite, dx_memread, dx_memwrite, stall_fd;
  logic [3:0]  dx_rs, dx_rt, dx_rd, dx_alu_op;
  logic [15:0] dx_rs_data, dx_rt_data, dx_imm, bubble_count, flush_count;

  logic        dx_valid_s, dx_regwrite_s, dx_memread_s, dx_memwrite_s, stall_fd_s;
  logic [3:0]  dx_rs_s, dx_rt_s, dx_rd_s, dx_alu_op_s, bubble_count_s, flush_count_s;
  logic [15:0] dx_rs_data_s, dx_rt_data_s, dx_imm_s;

  dx_hazard_reg dut (
    .clk(clk), .rst(rst), .fd_valid(fd_valid), .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_rd(fd_rd),
    .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt), .fd_rs_data(fd_rs_data),
    .fd_rt_data(fd_rt_data), .fd_imm(fd_imm), .fd_regwrite(fd_regwrite),
    .fd_memread(fd_memread), .fd_memwrite(fd_memwrite), .fd_alu_op(fd_alu_op),
    .flush(flush), .ext_stall(ext_stall), .dx_valid(dx_valid), .dx_regwrite(dx_regwrite),
    .dx_memread(dx_memread), .dx_memwrite(dx_memwrite), .dx_rs(dx_rs), .dx_rt(dx_rt),
    .dx_rd(dx_rd), .dx_rs_data(dx_rs_data), .dx_rt_data(dx_rt_data), .dx_imm(dx_imm),
    .dx_alu_op(dx_alu_op), .stall_fd(stall_fd), .bubble_count(bubble_count),
    .flush_count(flush_count)
  );

  dx_hazard_reg #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .fd_valid(fd_valid), .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_rd(fd_rd),
    .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt), .fd_rs_data(fd_rs_data),
    .fd_rt_data(fd_rt_data), .fd_imm(fd_imm), .fd_regwrite(fd_regwrite),
    .fd_memread(fd_memread), .fd_memwrite(fd_memwrite), .fd_alu_op(fd_alu_op),
    .flush(flush), .ext_stall(ext_stall), .dx_valid(dx_valid_s), .dx_regwrite(dx_regwrite_s),
    .dx_memread(dx_memread_s), .dx_memwrite(dx_memwrite_s), .dx_rs(dx_rs_s), .dx_rt(dx_rt_s),
    .dx_rd(dx_rd_s), .dx_rs_data(dx_rs_data_s), .dx_rt_data(dx_rt_data_s), .dx_imm(dx_imm_s),
    .dx_alu_op(dx_alu_op_s), .stall_fd(stall_fd_s), .bubble_count(bubble_count_s),
    .flush_count(flush_count_s)
  );

  typedef struct packed {
    logic        valid, regwrite, memread, memwrite;
    logic [3:0]  rs, rt, rd, alu_op;
    logic [15:0] rs_data, rt_data, imm;
  } dx_t;

  typedef struct packed {
    dx_t         dx;
    logic [15:0] bc, fc;
    logic [3:0]  bc4, fc4;
  } exp_t;

  dx_t  got_a, got_b, m;
  exp_t q[$];
  logic [15:0] m_bc, m_fc;
  logic [3:0]  m_bc4, m_fc4;
  int n_chk = 0, n_err = 0;

  assign got_a = {dx_valid, dx_regwrite, dx_memread, dx_memwrite, dx_rs, dx_rt, dx_rd,
                  dx_alu_op, dx_rs_data, dx_rt_data, dx_imm};
  assign got_b = {dx_valid_s, dx_regwrite_s, dx_memread_s, dx_memwrite_s, dx_rs_s, dx_rt_s,
                  dx_rd_s, dx_alu_op_s, dx_rs_data_s, dx_rt_data_s, dx_imm_s};

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h @%0t", tag, got, exp, $time);
    end
  endtask

  // Load-use hazard seen by the instruction in IF/ID against the model's ID/EX state.
  function automatic logic lu_f();
    logic rs_m, rt_m;
    rs_m = fd_uses_rs && (fd_rs == m.rd);
    rt_m = fd_uses_rt && (fd_rt == m.rd) && !fd_memwrite;
    return fd_valid && m.valid && m.memread && m.regwrite && (m.rd != 4'd0) && (rs_m || rt_m);
  endfunction

  task automatic cyc();
    exp_t e;
    dx_t  cap;
    logic lu, st_exp;
    #1;
    lu     = lu_f();
    st_exp = !rst && (ext_stall || (!flush && lu));
    chk("stall_fd", 96'(stall_fd), 96'(st_exp));
    chk("stall_fd_s", 96'(stall_fd_s), 96'(st_exp));
    cap = '{valid: fd_valid, regwrite: fd_valid & fd_regwrite, memread: fd_valid & fd_memread,
            memwrite: fd_valid & fd_memwrite, rs: fd_rs, rt: fd_rt, rd: fd_rd,
            alu_op: fd_alu_op, rs_data: fd_rs_data, rt_data: fd_rt_data, imm: fd_imm};
    if (rst) begin
      m = '0; m_bc = '0; m_fc = '0; m_bc4 = '0; m_fc4 = '0;
    end else if (!ext_stall) begin
      if (flush) begin
        m = '0;
        if (m_fc != 16'hFFFF) m_fc++;
        if (m_fc4 != 4'hF) m_fc4++;
      end else if (lu) begin
        m = '0;
        if (m_bc != 16'hFFFF) m_bc++;
        if (m_bc4 != 4'hF) m_bc4++;
      end else begin
        m = cap;
      end
    end
    e = '{dx: m, bc: m_bc, fc: m_fc, bc4: m_bc4, fc4: m_fc4};
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("dx", 96'(got_a), 96'(e.dx));
    chk("dx_s", 96'(got_b), 96'(e.dx));
    chk("bubble_count", 96'(bubble_count), 96'(e.bc));
    chk("flush_count", 96'(flush_count), 96'(e.fc));
    chk("bubble_count_s", 96'(bubble_count_s), 96'(e.bc4));
    chk("flush_count_s", 96'(flush_count_s), 96'(e.fc4));
  endtask

  task automatic drive(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                       input logic [3:0] rd, input logic urs, input logic urt,
                       input logic rw, input logic mr, input logic mw, input logic [3:0] alu);
    fd_valid = v; fd_rs = rs; fd_rt = rt; fd_rd = rd;
    fd_uses_rs = urs; fd_uses_rt = urt;
    fd_regwrite = rw; fd_memread = mr; fd_memwrite = mw; fd_alu_op = alu;
    fd_rs_data = 16'($urandom); fd_rt_data = 16'($urandom); fd_imm = 16'($urandom);
  endtask

  task automatic ld(input logic [3:0] rd);
    drive(1'b1, 4'd1, 4'd2, rd, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
  endtask
  task automatic add(input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd);
    drive(1'b1, rs, rt, rd, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2);
  endtask
  task automatic st(input logic [3:0] rs, input logic [3:0] rt);
    drive(1'b1, rs, rt, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    m = '0; m_bc = '0; m_fc = '0; m_bc4 = '0; m_fc4 = '0;
    rst = 1'b1; flush = 1'b0; ext_stall = 1'b0;
    add(4'd1, 4'd2, 4'd3);
    cyc(); cyc();
    rst = 1'b0;

    // Load-use on rs: one bubble then capture.
    ld(4'd3); cyc();
    add(4'd3, 4'd4, 4'd5); cyc(); cyc();
    // Store whose only match is rt data: no stall.
    ld(4'd3); cyc();
    st(4'd5, 4'd3); cyc();
    // Load to R0 never stalls.
    ld(4'd0); cyc();
    add(4'd0, 4'd0, 4'd6); cyc();
    // Flush wins over load-use.
    ld(4'd3); cyc();
    add(4'd3, 4'd3, 4'd6); flush = 1'b1; cyc(); flush = 1'b0;
    // External stall holds everything for 3 cycles.
    ld(4'd4); cyc();
    ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      add(4'(i), 4'd4, 4'd9); cyc();
    end
    ext_stall = 1'b0; cyc();
    // Invalid slot with control bits set: fields captured, control forced low.
    drive(1'b0, 4'd2, 4'd3, 4'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h7); cyc();
    // Reset in the middle of a load-use stall.
    ld(4'd3); cyc();
    add(4'd3, 4'd1, 4'd2); rst = 1'b1; cyc();
    rst = 1'b0; cyc();

    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 4'($urandom));
      flush     = ($urandom_range(0, 9) == 0);
      ext_stall = ($urandom_range(0, 9) == 0);
      rst       = ($urandom_range(0, 49) == 0);
      cyc();
    end
    rst = 1'b0; flush = 1'b0; ext_stall = 1'b0;

    // Drive both counters well past the small instance's saturation point.
    for (int i = 0; i < 20; i++) begin
      ld(4'd3); cyc();
      add(4'd3, 4'd1, 4'd2); cyc();
    end
    flush = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    flush = 1'b0;
    ld(4'd3); cyc();
    add(4'd1, 4'd3, 4'd2); cyc();
    rst = 1'b1; cyc();
    rst = 1'b0; cyc();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
